// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default widths for the shift-add MAC
package mac_pkg;

    localparam int MAC_N     = 8;
    localparam int MAC_ACC_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequencing FSM for the shift-add MAC
//   clk, rst : clock, synchronous active-high reset
//   start    : operation request, honoured only in IDLE
//   clr_acc  : accumulator clear request, honoured only in IDLE or DONE
//   state    : current FSM state, decoded by the datapath
//   load     : operand capture strobe (IDLE and start)
//   clr_en   : qualified accumulator clear
//   busy     : registered, high in MUL and ACC
//   done     : registered, high for the single DONE cycle
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int N = MAC_N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clr_acc,
    output mac_state_t state,
    output logic       load,
    output logic       clr_en,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt;

    assign load   = (state == IDLE) && start;
    assign clr_en = clr_acc && ((state == IDLE) || (state == DONE));

    // busy/done are set on the transition into their states so they are
    // registered yet still aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MUL;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    // fixed N steps, no early exit on a zero multiplier
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - generic W-bit 2-to-1 multiplexer from the mux library
//   sel : select, 0 picks d0, 1 picks d1
//   d0  : input 0
//   d1  : input 1
//   y   : selected output
module mux2 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mac_seq_unit.sv
// rtl/mac_seq_unit.sv - sequential shift-add multiply with wrapping accumulator
//   clk, rst : clock, synchronous active-high reset
//   start    : begin an operation (IDLE only)
//   clr_acc  : clear acc and ovf (IDLE or DONE only)
//   a, b     : N-bit multiplicand / multiplier, captured on start
//   busy     : high in MUL and ACC
//   done     : one-cycle completion pulse
//   product  : last completed 2N-bit product, cleared on start
//   acc      : ACC_W-bit wrapping accumulator
//   ovf      : sticky accumulator carry-out
module mac_seq_unit
    import mac_pkg::*;
#(
    parameter int N     = MAC_N,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_acc,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    mac_state_t     state;
    logic           load;
    logic           clr_en;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] partial_sum;
    logic [2*N-1:0] product_step;
    logic [ACC_W:0] acc_sum;

    mac_seq_ctrl #(.N(N)) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clr_acc (clr_acc),
        .state   (state),
        .load    (load),
        .clr_en  (clr_en),
        .busy    (busy),
        .done    (done)
    );

    // product + mcand never exceeds 2N bits: mcand only ever holds a << i
    // for the bits of b still being consumed.
    assign partial_sum = product + mcand;

    mux2 #(.W(2 * N)) u_add_sel (
        .sel (mplier[0]),
        .d0  (product),
        .d1  (partial_sum),
        .y   (product_step)
    );

    // one extra bit captures the carry that feeds the sticky flag
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(product);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            if (load) begin
                mcand   <= {{N{1'b0}}, a};
                mplier  <= b;
                product <= '0;
            end
            if (state == MUL) begin
                product <= product_step;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
            end
            if (state == ACC) begin
                acc <= acc_sum[ACC_W-1:0];
                ovf <= ovf | acc_sum[ACC_W];
            end else if (clr_en) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_unit.sv
// tb/tb_mac_seq_unit.sv - scoreboard bench for mac_seq_unit
module tb_mac_seq_unit;

    localparam int N     = 8;
    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             clr_acc = 1'b0;
    logic [N-1:0]     a = '0;
    logic [N-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    mac_seq_unit #(.N(N), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .clr_acc (clr_acc),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .acc     (acc),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int pcyc = 0;
    always @(posedge clk) pcyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned p;
        int unsigned acc;
        int unsigned ovf;
        int          cyc;
    } exp_t;

    exp_t sbq[$];

    // reference model state: accumulator as a plain integer mod 2^ACC_W
    longint m_acc = 0;
    int     m_ovf = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", pcyc, e.cyc);
                    chk("product", product, e.p);
                    chk("acc", acc, e.acc);
                    chk("ovf", ovf, e.ovf);
                end
            end
        end
    end

    task automatic do_clr();
        @(negedge clk);
        clr_acc = 1'b1;
        m_acc = 0;
        m_ovf = 0;
        @(negedge clk);
        clr_acc = 1'b0;
    endtask

    // one operation; disturb = re-assert start / change operands mid-run
    // and request start in DONE; clr_mid = clr_acc during MUL;
    // rst_at = MUL cycle at which reset is asserted (0 = none)
    task automatic op(input int oa, input int ob, input bit clr,
                      input bit disturb, input bit clr_mid, input int rst_at);
        exp_t   e;
        longint s;
        @(negedge clk);
        a = N'(oa);
        b = N'(ob);
        start = 1'b1;
        clr_acc = clr;
        if (clr) begin
            m_acc = 0;
            m_ovf = 0;
        end
        s = m_acc + longint'(oa) * longint'(ob);
        if (s >= (longint'(1) << ACC_W)) m_ovf = 1;
        m_acc = s % (longint'(1) << ACC_W);
        e.p   = oa * ob;
        e.acc = int'(m_acc);
        e.ovf = m_ovf;
        e.cyc = pcyc + N + 2;
        sbq.push_back(e);
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge clk);
            chk("busy", busy, (k <= N + 1) ? 1 : 0);
            if (k == 1) begin
                start = 1'b0;
                clr_acc = 1'b0;
                a = N'($urandom);
                b = N'($urandom);
            end
            if (clr_mid && k == 2) clr_acc = 1'b1;
            if (clr_mid && k == 3) clr_acc = 1'b0;
            if (disturb && k == 3) begin
                start = 1'b1;
                a = 8'd200;
                b = 8'd200;
            end
            if (disturb && k == 4) start = 1'b0;
            if (rst_at != 0 && k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_product", product, 0);
                chk("rst_acc", acc, 0);
                chk("rst_ovf", ovf, 0);
                sbq.delete(sbq.size() - 1);
                m_acc = 0;
                m_ovf = 0;
                for (int j = 0; j < N + 6; j++) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                end
                return;
            end
        end
        if (disturb) begin
            start = 1'b1;
            a = 8'd1;
            b = 8'd1;
            @(negedge clk);
            start = 1'b0;
            chk("done_start_ignored", busy, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        chk("reset_acc", acc, 0);
        chk("reset_ovf", ovf, 0);
        rst = 1'b0;

        do_clr();
        op(13, 11, 0, 0, 0, 0);
        op(255, 255, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_acc", acc, 65168);

        do_clr();
        for (int i = 0; i < 16; i++) op(255, 255, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_acc16", acc, 1040400);
        chk("t3_ovf16", ovf, 0);
        op(255, 255, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_acc17", acc, 56849);
        chk("t3_ovf17", ovf, 1);
        op(1, 1, 0, 0, 0, 0);

        op(5, 6, 0, 0, 1, 0);
        op(3, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk("t4_acc", acc, 0);
        op(7, 9, 0, 1, 0, 0);

        op(100, 100, 0, 0, 0, 0);
        op(50, 50, 0, 0, 0, 4);
        op(2, 3, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int ra, rb;
            ra = (i % 10 == 0) ? 0 : int'($urandom_range(0, 255));
            rb = (i % 10 == 5) ? 255 : int'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) do_clr();
            op(ra, rb, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
